// File: rtl/avalon_ram_arbiter_pkg.sv
// Shared definitions for the three-master main-memory arbiter.
package avalon_ram_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int NUM_MASTERS = 3;

  localparam logic [1:0] MST_DEBUG = 2'd0;
  localparam logic [1:0] MST_DBUS  = 2'd1;
  localparam logic [1:0] MST_IBUS  = 2'd2;

endpackage

// File: rtl/avalon_ram_arbiter_arb_priority_rr.sv
// Winner selection: debug has fixed top priority; dbus and ibus alternate
// when they contend, favouring the one not served most recently.
module arb_priority_rr
  import avalon_ram_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             last_served,
  output logic [1:0]             winner,
  output logic                   valid
);

  // Combinational pick of the winning master index.
  always_comb begin
    winner = MST_DEBUG;
    valid  = |req;
    if (req[MST_DEBUG]) begin
      winner = MST_DEBUG;
    end else if (req[MST_DBUS] && req[MST_IBUS]) begin
      winner = (last_served == MST_DBUS) ? MST_IBUS : MST_DBUS;
    end else if (req[MST_DBUS]) begin
      winner = MST_DBUS;
    end else if (req[MST_IBUS]) begin
      winner = MST_IBUS;
    end
  end

endmodule

// File: rtl/avalon_ram_arbiter.sv
// Arbitrates the debug, dbus and ibus Avalon masters onto one memory port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | slave port quiet, all masters stalled, arbitration sampled
// ST_GRANT | master g owns the slave port until completion or it drops
module avalon_ram_arbiter
  import avalon_ram_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*AW-1:0]     m_address,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_byte_enable,
  input  logic [NUM_MASTERS*DW-1:0]     m_writedata,
  output logic [DW-1:0]                 m_readdata,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic                          s_read,
  output logic                          s_write,
  output logic [AW-1:0]                 s_address,
  output logic [DW/8-1:0]               s_byte_enable,
  output logic [DW-1:0]                 s_writedata,
  input  logic [DW-1:0]                 s_readdata,
  input  logic                          s_waitrequest
);

  state_t     state, state_nxt;
  logic [1:0] g, g_nxt;
  logic [1:0] last_served, last_nxt;

  logic [1:0] arb_winner;
  logic       arb_valid;

  logic            sel_read;
  logic            sel_write;
  logic [AW-1:0]   sel_address;
  logic [DW/8-1:0] sel_byte_enable;
  logic [DW-1:0]   sel_writedata;

  arb_priority_rr u_arb (
    .req         (m_read | m_write),
    .last_served (last_served),
    .winner      (arb_winner),
    .valid       (arb_valid)
  );

  assign m_readdata = s_readdata;

  // Register state, grant owner and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      g           <= MST_DEBUG;
      last_served <= MST_IBUS;
    end else begin
      state       <= state_nxt;
      g           <= g_nxt;
      last_served <= last_nxt;
    end
  end

  // Select the fields of the master currently holding the grant.
  always_comb begin
    sel_read        = 1'b0;
    sel_write       = 1'b0;
    sel_address     = '0;
    sel_byte_enable = '0;
    sel_writedata   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (g == i[1:0]) begin
        sel_read        = m_read[i];
        sel_write       = m_write[i];
        sel_address     = m_address[i*AW +: AW];
        sel_byte_enable = m_byte_enable[i*(DW/8) +: DW/8];
        sel_writedata   = m_writedata[i*DW +: DW];
      end
    end
  end

  // Next-state and slave/master handshake outputs.
  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    last_nxt      = last_served;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_address     = '0;
    s_byte_enable = '0;
    s_writedata   = '0;
    m_waitrequest = '1;
    unique case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          state_nxt = ST_GRANT;
          g_nxt     = arb_winner;
        end
      end
      ST_GRANT: begin
        s_read        = sel_read;
        // A simultaneous read and write from one master is issued as a read.
        s_write       = sel_write & ~sel_read;
        s_address     = sel_address;
        s_byte_enable = sel_byte_enable;
        s_writedata   = sel_writedata;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (g == i[1:0]) m_waitrequest[i] = s_waitrequest;
        end
        if (!(sel_read || sel_write)) begin
          state_nxt = ST_IDLE;
        end else if (!s_waitrequest) begin
          state_nxt = ST_IDLE;
          if (g != MST_DEBUG) last_nxt = g;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_avalon_ram_arbiter.sv
// Self-checking bench for avalon_ram_arbiter: directed vector table,
// multi-cycle contention/priority sequences and a randomized run against
// a transaction-level reference model.
module tb_avalon_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic           clk;
  logic           rst;
  logic [2:0]     m_read, m_write;
  logic [3*AW-1:0] m_address;
  logic [3*DW/8-1:0] m_byte_enable;
  logic [3*DW-1:0] m_writedata;
  logic [DW-1:0]  m_readdata;
  logic [2:0]     m_waitrequest;
  logic           s_read, s_write;
  logic [AW-1:0]  s_address;
  logic [DW/8-1:0] s_byte_enable;
  logic [DW-1:0]  s_writedata;
  logic [DW-1:0]  s_readdata;
  logic           s_waitrequest;

  int errors = 0;
  int checks = 0;

  avalon_ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_byte_enable (m_byte_enable),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_address     (s_address),
    .s_byte_enable (s_byte_enable),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .s_waitrequest (s_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic        swait;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [2:0]  exp_wait;
  } vec_t;

  function automatic vec_t v(logic r, logic [2:0] rd, logic [2:0] wr, logic sw,
                             logic erd, logic ewr, logic [31:0] ea, logic [3:0] ebe,
                             logic [31:0] ewd, logic [2:0] ew);
    vec_t t;
    t.rst = r; t.rd = rd; t.wr = wr; t.swait = sw;
    t.exp_rd = erd; t.exp_wr = ewr; t.exp_addr = ea; t.exp_be = ebe;
    t.exp_wd = ewd; t.exp_wait = ew;
    return t;
  endfunction

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [104:0] bundle();
    return {s_read, s_write, s_address, s_byte_enable, s_writedata, m_waitrequest, m_readdata};
  endfunction

  // Reference: who would win an arbitration given requests and history.
  function automatic int pick(logic [2:0] req, int last);
    if (req[0]) return 0;
    if (req[1] && req[2]) return (last == 1) ? 2 : 1;
    return req[1] ? 1 : 2;
  endfunction

  // Reference: slave-side view when master o owns the port (o < 0: nobody).
  function automatic logic [104:0] model_out(int o);
    logic        rd, wr;
    logic [2:0]  w;
    if (o < 0) return {2'b00, 32'h0, 4'h0, 32'h0, 3'b111, s_readdata};
    rd = m_read[o];
    wr = m_write[o] && !m_read[o];
    w  = 3'b111;
    w[o] = s_waitrequest;
    return {rd, wr, m_address[o*AW +: AW], m_byte_enable[o*4 +: 4],
            m_writedata[o*DW +: DW], w, s_readdata};
  endfunction

  task automatic set_fixed_fields();
    m_address     = {32'h0000_0100, 32'h0000_0200, 32'h0000_0300};
    m_byte_enable = {4'hF, 4'h3, 4'hF};
    m_writedata   = {32'hCCCC_2222, 32'h1234_5678, 32'hAAAA_0000};
    s_readdata    = 32'hDEAD_BEEF;
  endtask

  vec_t tbl[26];
  int   owner;
  int   last;
  int   order[8];
  int   n;
  int   cyc;
  logic [2:0] pending;
  int   done_m;
  int   cnt1, cnt2;

  initial begin
    // Idle outputs expressed as row fields.
    tbl[0]  = v(0, 3'b000, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[1]  = v(1, 3'b100, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[2]  = v(1, 3'b100, 3'b000, 0, 1, 0, 32'h100, 4'hF, 32'hCCCC_2222,  3'b011);
    tbl[3]  = v(1, 3'b000, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[4]  = v(1, 3'b100, 3'b100, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[5]  = v(1, 3'b100, 3'b100, 0, 1, 0, 32'h100, 4'hF, 32'hCCCC_2222,  3'b011);
    tbl[6]  = v(1, 3'b000, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[7]  = v(1, 3'b000, 3'b010, 1, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[8]  = v(1, 3'b000, 3'b010, 1, 0, 1, 32'h200, 4'h3, 32'h1234_5678,  3'b111);
    tbl[9]  = v(1, 3'b000, 3'b010, 1, 0, 1, 32'h200, 4'h3, 32'h1234_5678,  3'b111);
    tbl[10] = v(1, 3'b000, 3'b010, 1, 0, 1, 32'h200, 4'h3, 32'h1234_5678,  3'b111);
    tbl[11] = v(1, 3'b000, 3'b010, 0, 0, 1, 32'h200, 4'h3, 32'h1234_5678,  3'b101);
    tbl[12] = v(1, 3'b000, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[13] = v(1, 3'b100, 3'b000, 1, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[14] = v(1, 3'b000, 3'b000, 1, 0, 0, 32'h100, 4'hF, 32'hCCCC_2222,  3'b111);
    tbl[15] = v(1, 3'b000, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[16] = v(1, 3'b110, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[17] = v(1, 3'b110, 3'b000, 0, 1, 0, 32'h100, 4'hF, 32'hCCCC_2222,  3'b011);
    tbl[18] = v(1, 3'b010, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[19] = v(1, 3'b010, 3'b000, 0, 1, 0, 32'h200, 4'h3, 32'h1234_5678,  3'b101);
    tbl[20] = v(1, 3'b000, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[21] = v(1, 3'b001, 3'b000, 1, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[22] = v(0, 3'b001, 3'b000, 1, 1, 0, 32'h300, 4'hF, 32'hAAAA_0000,  3'b111);
    tbl[23] = v(1, 3'b001, 3'b000, 1, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);
    tbl[24] = v(1, 3'b001, 3'b000, 0, 1, 0, 32'h300, 4'hF, 32'hAAAA_0000,  3'b110);
    tbl[25] = v(1, 3'b000, 3'b000, 0, 0, 0, 32'h0,   4'h0, 32'h0,          3'b111);

    rst = 1'b0; m_read = '0; m_write = '0; s_waitrequest = 1'b0;
    set_fixed_fields();
    tick();

    // Directed vectors: single read, read+write, wait states, abort, reset mid-grant.
    for (int i = 0; i < 26; i++) begin
      rst = tbl[i].rst; m_read = tbl[i].rd; m_write = tbl[i].wr;
      s_waitrequest = tbl[i].swait;
      @(negedge clk);
      check($sformatf("vec%0d", i), bundle(),
            {tbl[i].exp_rd, tbl[i].exp_wr, tbl[i].exp_addr, tbl[i].exp_be,
             tbl[i].exp_wd, tbl[i].exp_wait, 32'hDEAD_BEEF});
      tick();
    end

    // Contention between dbus and ibus from reset: strict alternation.
    rst = 1'b0; m_read = '0; m_write = '0; s_waitrequest = 1'b0;
    tick();
    rst = 1'b1; m_read = 3'b110;
    n = 0; cnt1 = 0; cnt2 = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (s_read && !s_waitrequest) begin
        for (int i = 0; i < 3; i++) begin
          if (!m_waitrequest[i]) begin
            check($sformatf("contend_grant%0d", n), i, (n % 2 == 0) ? 1 : 2);
            if (i == 1) cnt1++;
            if (i == 2) cnt2++;
            n++;
          end
        end
      end
      tick();
    end
    check("contend_count", {cnt1, cnt2}, {32'd4, 32'd4});

    // Debug does not pre-empt a stalled dbus access; then debug, then ibus.
    rst = 1'b0; m_read = '0; s_waitrequest = 1'b0;
    tick();
    rst = 1'b1; m_read = 3'b010;
    tick();
    m_read = 3'b111; s_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("prio_hold%0d", k), {m_waitrequest, s_read, s_address},
            {3'b111, 1'b1, 32'h200});
      tick();
    end
    s_waitrequest = 1'b0; pending = 3'b111; n = 0; cyc = 0;
    while (pending != 3'b000 && cyc < 30) begin
      @(negedge clk);
      done_m = -1;
      if (s_read && !s_waitrequest) begin
        for (int i = 0; i < 3; i++) if (!m_waitrequest[i]) done_m = i;
      end
      tick();
      if (done_m >= 0) begin
        if (n < 8) order[n] = done_m;
        n++;
        pending[done_m] = 1'b0;
      end
      m_read = pending;
      cyc++;
    end
    check("prio_timeout", pending, 3'b000);
    check("prio_order", {n, order[0], order[1], order[2]}, {32'd3, 32'd1, 32'd0, 32'd2});

    // Randomized traffic against the reference model.
    rst = 1'b0; m_read = '0; m_write = '0; s_waitrequest = 1'b0;
    tick();
    owner = -1; last = 2;
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 63) != 0);
      m_read        = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      m_write       = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      m_address     = {$urandom, $urandom, $urandom};
      m_byte_enable = 12'($urandom);
      m_writedata   = {$urandom, $urandom, $urandom};
      s_readdata    = $urandom;
      s_waitrequest = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      check("rand", bundle(), model_out(owner));
      @(posedge clk);
      if (!rst) begin
        owner = -1; last = 2;
      end else if (owner < 0) begin
        if ((m_read | m_write) != 3'b000) owner = pick(m_read | m_write, last);
      end else if (!(m_read[owner] || m_write[owner])) begin
        owner = -1;
      end else if (!s_waitrequest) begin
        if (owner != 0) last = owner;
        owner = -1;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_ram_arbiter.md
AVALON_RAM_ARBITER -- requirements
Module: avalon_ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; byte-enable width is DW/8.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port m_read, input, 3: per-master read request; index 0 = debug, 1 = dbus, 2 = ibus.
REQ-006 SHALL have port m_write, input, 3: per-master write request.
REQ-007 SHALL have port m_address, input, 3*AW: packed per-master byte address.
REQ-008 SHALL have port m_byte_enable, input, 3*DW/8: packed per-master byte enables.
REQ-009 SHALL have port m_writedata, input, 3*DW: packed per-master write data.
REQ-010 SHALL have port m_readdata, output, DW: shared read data returned to all masters.
REQ-011 SHALL have port m_waitrequest, output, 3: per-master stall.
REQ-012 SHALL have ports s_read, s_write, s_address, s_byte_enable and s_writedata, all outputs, of widths 1, 1, AW, DW/8 and DW: the main-memory request.
REQ-013 SHALL have ports s_readdata (input, DW) and s_waitrequest (input, 1): the main-memory response.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and GRANT, with a 2-bit grant register g.
REQ-015 In IDLE, s_read and s_write SHALL be 0, s_address, s_byte_enable and s_writedata SHALL be 0, and m_waitrequest SHALL be 3'b111.
REQ-016 In IDLE, if any m_read[i] or m_write[i] is set, the FSM SHALL go to GRANT on the next edge and load g with the winner.
REQ-017 Winner selection: master 0 wins whenever it requests (fixed priority). Otherwise, if masters 1 and 2 both request, the one not recorded in last_served wins. Otherwise the single requester wins.
REQ-018 In GRANT, the s_* request signals SHALL be a combinational mux of master g.
REQ-019 In GRANT, m_waitrequest[g] SHALL equal s_waitrequest, and every other m_waitrequest bit SHALL be 1.
REQ-020 m_readdata SHALL equal s_readdata at all times; read data is valid for master g in the cycle where s_read=1 and s_waitrequest=0.
REQ-021 Completion is (s_read|s_write) & ~s_waitrequest. On completion the FSM SHALL return to IDLE, and if g is 1 or 2, last_served SHALL be set to g.
REQ-022 If master g drops both read and write while in GRANT, the FSM SHALL return to IDLE without issuing an access, and last_served SHALL be unchanged.
REQ-023 If master g asserts read and write together, s_write SHALL be forced to 0 so that the read takes precedence.
REQ-024 Latency: a request sampled in IDLE at cycle N SHALL reach the slave at N+1; with a zero-wait slave, completion is at N+1 and the FSM is in IDLE at N+2 (2 cycles per transaction, one bubble).
REQ-025 A request arriving while another master holds the grant SHALL stall, with m_waitrequest=1, until it wins a later IDLE arbitration; requests are never dropped.
REQ-026 Master 0 SHALL NOT pre-empt a transaction already in GRANT; it wins at the next IDLE.

Reset
REQ-027 While rst=0 at a clock edge, the FSM SHALL go to IDLE, g SHALL be 0, and last_served SHALL be 2 (dbus is preferred first).
REQ-028 During and after reset, outputs SHALL take the REQ-015 values from the first post-reset cycle onward.
REQ-029 Reset asserted mid-GRANT SHALL abandon the transaction, with s_read and s_write low after that edge; no retry is performed.

Structure
REQ-030 The FSM state enum, the master index constants (MST_DEBUG=0, MST_DBUS=1, MST_IBUS=2) and the number of masters (3) SHALL live in the shared SoC package/header.
REQ-031 The winner selection logic SHALL be one sub-module, arb_priority_rr, which is combinational and takes the request vector and last_served and returns the winner index and a valid flag.
REQ-032 The block SHALL drive main memory through the avalon_ram_1rw or SRAM controller port, and the SoC interconnect SHALL route the debug, dbus and ibus memory-space accesses through it.

Verification
REQ-033 Single read: only m_read[2]=1, address 0x100; slave zero-wait, s_readdata=0xDEADBEEF. Required: s_read=1 and s_address=0x100 at N+1; m_waitrequest=3'b011 at N+1 with m_readdata=0xDEADBEEF; IDLE at N+2.
REQ-034 Contention: masters 1 and 2 request continuously from reset, zero-wait slave. Required: grants alternate 1,2,1,2 and each master completes 1 access per 4 cycles.
REQ-035 Priority: masters 0 and 2 request together while master 1 is in GRANT with s_waitrequest=1 for 5 cycles. Required: master 1 is not pre-empted and completes; master 0 is granted next, then master 2.
REQ-036 Wait states: m_write[1]=1, writedata 0x12345678, byte_enable 4'b0011; slave holds waitrequest for 3 cycles. Required: s_* stable and m_waitrequest[1]=1 for 3 cycles, then 0 for 1 cycle; IDLE next.
REQ-037 Abort: the granted master drops its request in GRANT. Required: IDLE next cycle and last_served unchanged. Separately, rst=0 mid-GRANT: s_read=s_write=0 and m_waitrequest=3'b111 after the edge.
REQ-038 Read and write both asserted by master 2. Required: s_read=1 and s_write=0.
